// File: rtl/instr_loader.sv
// Framed byte-stream boot loader: LEN_LO, LEN_HI, 4N little-endian payload bytes, XOR CHK; writes imem, releases cpu_hold on a good frame.
// Latency: write strobe one cycle after each word's 4th byte; 1 byte/cycle sustained; byte_ready drops outside a frame, stalls wait forever.
module instr_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [7:0]  chk;
  logic [15:0] len_m1;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [15:0] n;
  logic        xfer, len_ok, last_byte, last_word, enter_len, active_nxt;

  assign xfer      = byte_valid && byte_ready;
  assign n         = {byte_in, len_lo};
  assign len_ok    = (n != 16'd0) && ({1'b0, n} <= DEPTH_L);
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == len_m1);
  assign enter_len = start && (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = S_LEN_LO;
      S_LEN_LO:        if (xfer) state_nxt = S_LEN_HI;
      S_LEN_HI:        if (xfer) state_nxt = len_ok ? S_DATA : ERR;
      S_DATA:          if (xfer && last_byte && last_word) state_nxt = S_CHK;
      S_CHK:           if (xfer) state_nxt = (byte_in == chk) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  assign active_nxt = (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                      (state_nxt == S_DATA)   || (state_nxt == S_CHK);

  // Status outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= state_nxt;
      byte_ready <= active_nxt;
      busy       <= active_nxt;
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERR);
      cpu_hold   <= (state_nxt != DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      len_m1     <= '0;
      chk        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (enter_len) begin
        chk      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
      end else if (xfer) begin
        case (state)
          S_LEN_LO: begin
            len_lo <= byte_in;
            chk    <= chk ^ byte_in;
          end
          S_LEN_HI: begin
            len_m1 <= n - 16'd1;
            chk    <= chk ^ byte_in;
          end
          S_DATA: begin
            chk      <= chk ^ byte_in;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_wdata <= {byte_in, word_buf};
              imem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
              word_idx   <= word_idx + 16'd1;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= byte_in;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: frames are built from word lists, expected writes and outcome come from the frame rules.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, imem_we, busy, done, error, cpu_hold;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] exp_w[$];
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(10), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  end

  // Frame = length field, payload words LSB first, then XOR of all prior bytes (optionally corrupted).
  task automatic build_frame(input logic [15:0] len_field, input logic [7:0] chk_flip);
    logic [7:0] x;
    logic [31:0] w;
    frame_q = {};
    frame_q.push_back(len_field[7:0]);
    frame_q.push_back(len_field[15:8]);
    foreach (exp_w[i]) begin
      w = exp_w[i];
      for (int k = 0; k < 4; k++) frame_q.push_back(w[8*k +: 8]);
    end
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    frame_q.push_back(x ^ chk_flip);
  endtask

  task automatic random_words(input int nw);
    exp_w = {};
    for (int i = 0; i < nw; i++) exp_w.push_back($urandom);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input bit mid_start, input int nbytes);
    int idx = 0;
    int cyc = 0;
    bit x_now;
    while (idx < nbytes && cyc < 20000) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_valid ? frame_q[idx] : 8'($urandom);
      start      = mid_start && ($urandom_range(0, 5) == 0);
      x_now      = byte_valid && byte_ready;
      tick();
      if (x_now) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (idx < nbytes) begin
      errors++;
      $display("FAIL send_timeout sent %0d bytes, required %0d", idx, nbytes);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #12;
    checks++;
    if ({byte_ready, imem_we, busy, done, error, cpu_hold} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags got %b required 000001", {byte_ready, imem_we, busy, done, error, cpu_hold});
    end
    checks++;
    if (imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %h required 0 0", imem_addr, imem_wdata);
    end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({byte_ready, busy, done, error, cpu_hold} !== 5'b00001) begin
      errors++;
      $display("FAIL idle_flags got %b required 00001", {byte_ready, busy, done, error, cpu_hold});
    end
  endtask

  task automatic run_load(input string name, input bit gaps, input bit mid_start, input bit good_chk);
    int n = exp_w.size();
    wa_q = {}; wd_q = {};
    build_frame(16'(n), good_chk ? 8'h00 : 8'h01);
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_start got rdy %b busy %b done %b err %b hold %b required 1 1 0 0 1",
               name, byte_ready, busy, done, error, cpu_hold);
    end
    send_frame(gaps, mid_start, frame_q.size());
    checks++;
    if (wa_q.size() !== n) begin
      errors++;
      $display("FAIL %s_wr_count got %0d required %0d", name, wa_q.size(), n);
    end
    for (int i = 0; i < wa_q.size() && i < n; i++) begin
      checks++;
      if (wa_q[i] !== 10'(i * 4) || wd_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s_wr%0d got addr %h data %h required addr %h data %h",
                 name, i, wa_q[i], wd_q[i], 10'(i * 4), exp_w[i]);
      end
    end
    checks++;
    if (done !== good_chk || error !== !good_chk || cpu_hold !== !good_chk || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_result got done %b err %b hold %b busy %b rdy %b required done %b err %b hold %b busy 0 rdy 0",
               name, done, error, cpu_hold, busy, byte_ready, good_chk, !good_chk, !good_chk);
    end
  endtask

  task automatic test_good_load;
    exp_w = {32'h00500093, 32'h00108133};
    run_load("good", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_bad_chk;
    exp_w = {32'h00500093, 32'h00108133};
    run_load("badchk", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_len_bounds;
    logic [15:0] bad_len[2];
    bad_len[0] = 16'd0;
    bad_len[1] = 16'd257;
    for (int j = 0; j < 2; j++) begin
      wa_q = {}; wd_q = {};
      exp_w = {};
      build_frame(bad_len[j], 8'h00);
      pulse_start();
      send_frame(1'b0, 1'b0, 2);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
        errors++;
        $display("FAIL len%0d_err got err %b done %b busy %b hold %b required 1 0 0 1",
                 bad_len[j], error, done, busy, cpu_hold);
      end
      tick(); tick();
      checks++;
      if (wa_q.size() !== 0) begin
        errors++;
        $display("FAIL len%0d_nowrite got %0d writes required 0", bad_len[j], wa_q.size());
      end
    end
    random_words(256);
    run_load("len256", 1'b0, 1'b0, 1'b1);
    checks++;
    if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 10'h3FC) begin
      errors++;
      $display("FAIL len256_last_addr got %h required 3fc", wa_q.size() ? wa_q[wa_q.size()-1] : 10'h0);
    end
  endtask

  task automatic test_backpressure;
    exp_w = {32'h00500093, 32'h00108133};
    run_load("gaps_fixed", 1'b1, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      random_words($urandom_range(1, 9));
      run_load("gaps_rand", 1'b1, 1'b1, r != 2);
    end
  endtask

  task automatic test_reset_mid;
    random_words(3);
    wa_q = {}; wd_q = {};
    build_frame(16'd3, 8'h00);
    pulse_start();
    send_frame(1'b1, 1'b0, 7);
    reset = 1'b0;
    #1;
    checks++;
    if ({byte_ready, imem_we, busy, done, error, cpu_hold} !== 6'b000001 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midreset_vals got flags %b addr %h data %h required 000001 0 0",
               {byte_ready, imem_we, busy, done, error, cpu_hold}, imem_addr, imem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_in = 8'($urandom);
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'($urandom_range(0, 1)); byte_in = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 10'd0 || wd_q[0] !== exp_w[0]) begin
      errors++;
      $display("FAIL midreset_writes got %0d writes required 1 at addr 0 data %h", wa_q.size(), exp_w[0]);
    end
    random_words(4);
    run_load("after_reset", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reload;
    exp_w = {32'h00500093, 32'h00108133};
    run_load("preload", 1'b0, 1'b0, 1'b1);
    tick();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_hold got hold %b done %b busy %b required 1 0 1", cpu_hold, done, busy);
    end
    exp_w = {32'hDEADBEEF};
    wa_q = {}; wd_q = {};
    build_frame(16'd1, 8'h00);
    send_frame(1'b0, 1'b0, frame_q.size());
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'hDEADBEEF || done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reload_result got writes %0d done %b hold %b required 1 write deadbeef at 0, done 1 hold 0",
               wa_q.size(), done, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_chk();
    test_len_bounds();
    test_backpressure();
    test_reset_mid();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that writes the instruction memory the processor core fetches from. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive word-aligned instruction-memory addresses. The core is held in reset (`cpu_hold`) until a frame loads with a correct checksum, and then released.

## Interface
Parameters:
- `ADDR_W`, 10: byte-address width of instruction memory. It matches the 10-bit program counter.
- `DEPTH`, 256: maximum number of words per frame. It must not exceed 2^(ADDR_W-2).

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin a load.
- `byte_in`, in, 8: stream data.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: the loader accepts `byte_in` this cycle.
- `imem_we`, out, 1: instruction-memory write strobe, one cycle per word.
- `imem_addr`, out, ADDR_W: byte address of the write. Always a multiple of 4.
- `imem_wdata`, out, 32: assembled word.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: the last load completed successfully.
- `error`, out, 1: the last load failed.
- `cpu_hold`, out, 1: holds the processor core in reset while 1.

## Operation
- Frame format, in byte order:
  - `LEN_LO`, `LEN_HI`: 16-bit word count N.
  - 4N payload bytes, least-significant byte first within each word.
  - `CHK`: XOR of every preceding byte in the frame.
- A byte transfer occurs on a rising edge where `byte_valid && byte_ready`. Bytes presented while `byte_ready` is 0 are ignored.
- State machine transitions:
  - IDLE: `start` moves to S_LEN_LO.
  - S_LEN_LO: a transfer moves to S_LEN_HI.
  - S_LEN_HI: a transfer moves to S_DATA if 1 <= N <= DEPTH. N = 0 or N > DEPTH moves to ERR immediately, without waiting for `CHK`.
  - S_DATA: after 4N bytes are transferred, move to S_CHK.
  - S_CHK: a transfer moves to DONE if the running XOR equals `CHK`, otherwise to ERR.
  - DONE, ERR: `start` moves to S_LEN_LO.
- `start` in any state other than IDLE, DONE or ERR is ignored.
- Running checksum: cleared on entry to S_LEN_LO. XOR-accumulates every transferred byte except `CHK`.
- Word assembly: byte k of a word (k = 0..3) goes to bits [8k+7:8k]. Transfer of byte 3 produces a write.
- Address: the first write is at 0, and the address increments by 4 after each write. The address counter is cleared on entry to S_LEN_LO. No wrap occurs, because N <= DEPTH.
- Output values by state:
  - `byte_ready` = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK; 0 elsewhere.
  - `busy` = 1 in the same four states.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERR.
  - `cpu_hold` = 0 only in DONE.
- A restart from DONE re-asserts `cpu_hold` in the cycle after `start` is sampled.
- No readback and no partial-word flush: a frame that stalls mid-word waits indefinitely.

## Timing
- Reset values, with outputs taking them asynchronously while `reset` = 0:
  - State IDLE.
  - `byte_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `busy` = 0, `done` = 0, `error` = 0, `cpu_hold` = 1.
- All outputs are registered. A state entered at edge t is visible in the cycle after t.
- `start` sampled at edge t: `byte_ready` = 1 and `busy` = 1 from edge t.
- Write latency: the 4th byte of a word is transferred at edge t. `imem_we` = 1, with `imem_addr` and `imem_wdata` stable, for exactly the cycle following edge t. `imem_we` then returns to 0.
- Throughput: one byte per cycle is sustained. A byte transfer in the same cycle as `imem_we` is legal.
- The final word's write pulse coincides with the first S_CHK cycle.
- `CHK` transferred at edge t: `done` or `error` = 1 after edge t. `cpu_hold` falls after edge t on success.
- Reset asserted mid-frame: the load aborts, outputs return to reset values, and already-written words are not erased.

## Test plan
- Good load: `start`, then frame N=2, words 0x00500093 and 0x00108133, `CHK` = correct XOR, at 1 byte/cycle.
  - Two `imem_we` pulses: addr 0 data 0x00500093, then addr 4 data 0x00108133.
  - `done` = 1, `cpu_hold` = 0 after `CHK`.
- Bad checksum: same frame with `CHK` XOR 0x01.
  - Both writes still occur.
  - `error` = 1, `cpu_hold` stays 1, `done` = 0.
- Length bounds:
  - N=0 gives `error` after `LEN_HI`, with no writes.
  - N=257 (DEPTH=256) gives `error`, with no writes.
  - N=256 with a correct checksum gives 256 writes, last at addr 0x3FC, then `done`.
- Backpressure and gaps: `byte_valid` toggles randomly, and `start` pulses mid-frame.
  - The result is identical to the good-load case; the mid-frame `start` is ignored.
- Reset mid-frame: assert `reset` after 5 payload bytes.
  - Reset values are seen immediately and no further writes occur.
  - A subsequent `start` with a good frame completes with `done` = 1.
- Reload: `start` while in DONE.
  - `cpu_hold` = 1 in the next cycle.
  - A new N=1 frame (word 0xDEADBEEF) writes addr 0 and ends in `done`.
